// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronises the keyboard lines, validates
// start/parity/stop framing and buffers good bytes in a first-word-fall-through FIFO.
module ps2_frame_receiver #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PARITY_ODD     = 1
) (
  input  logic                          clk,
  input  logic                          sysReset,
  input  logic                          ps2Clk,
  input  logic                          ps2Data,
  output logic [DATA_BITS-1:0]          codeData,
  output logic                          codeValid,
  input  logic                          codeReady,
  output logic                          frameError,
  output logic [1:0]                    errorCode,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam int unsigned CW    = $clog2(DATA_BITS + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_STOP    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   fall_edge;
  logic                   sample;

  state_t                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   parity_bad_q, parity_bad_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   timeout_hit;

  logic                   push_req;
  logic                   err_valid;
  logic [1:0]             err_code;

  logic                   frame_error_q, frame_error_d;
  logic [1:0]             error_code_q, error_code_d;
  logic                   overflow_q, overflow_d;

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   pop;
  logic                   push_ok;

  // Line synchronisers; the previous-clock flop follows the last sync stage
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2Clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2Data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  end

  assign fall_edge = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign sample    = data_sync_q[SYNC_STAGES-1];

  assign timeout_hit = (state_q != ST_IDLE) && !fall_edge && (tmo_q == TMO_LAST);

  // FSM: state register
  always_ff @(posedge clk or posedge sysReset) begin
    if (sysReset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = ST_IDLE;
    end else if (fall_edge) begin
      case (state_q)
        ST_IDLE:   if (!sample) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt_q == BIT_LAST) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs (frame verdict in the stop-bit cycle, or timeout)
  always_comb begin
    push_req  = 1'b0;
    err_valid = 1'b0;
    err_code  = '0;
    if (timeout_hit) begin
      err_valid = 1'b1;
      err_code  = ERR_TIMEOUT;
    end else if (fall_edge && state_q == ST_STOP) begin
      if (!sample) begin
        err_valid = 1'b1;
        err_code  = ERR_STOP;
      end else if (parity_bad_q) begin
        err_valid = 1'b1;
        err_code  = ERR_PARITY;
      end else begin
        push_req = 1'b1;
      end
    end
  end

  // Frame datapath and inactivity counter
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    parity_bad_d = parity_bad_q;

    if (fall_edge || state_q == ST_IDLE) tmo_d = '0;
    else if (tmo_q != TMO_LAST)          tmo_d = tmo_q + TW'(1);
    else                                 tmo_d = tmo_q;

    if (fall_edge && !timeout_hit) begin
      case (state_q)
        ST_IDLE: begin
          if (!sample) begin
            bit_cnt_d    = '0;
            shreg_d      = '0;
            parity_bad_d = 1'b0;
          end
        end
        ST_DATA: begin
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt_q == CW'(i)) shreg_d[i] = sample;
          end
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
        ST_PARITY: parity_bad_d = ((^shreg_q) ^ sample) != 1'(PARITY_ODD);
        default: ;
      endcase
    end
  end

  // Error/overflow reporting
  always_comb begin
    frame_error_d = err_valid;
    error_code_d  = err_valid ? err_code : error_code_q;
    overflow_d    = push_req && !push_ok;
  end

  // FIFO; a push into a full FIFO still succeeds when the head is popped that cycle
  assign pop     = (count_q != '0) && codeReady;
  assign push_ok = push_req && ((count_q < CNT_W'(FIFO_DEPTH)) || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shreg_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge sysReset) begin
    if (sysReset) begin
      clk_sync_q    <= '1;
      data_sync_q   <= '1;
      clk_prev_q    <= 1'b1;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      parity_bad_q  <= 1'b0;
      tmo_q         <= '0;
      frame_error_q <= 1'b0;
      error_code_q  <= '0;
      overflow_q    <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      data_sync_q   <= data_sync_d;
      clk_prev_q    <= clk_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      parity_bad_q  <= parity_bad_d;
      tmo_q         <= tmo_d;
      frame_error_q <= frame_error_d;
      error_code_q  <= error_code_d;
      overflow_q    <= overflow_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  assign codeData   = mem_q[rd_ptr_q];
  assign codeValid  = (count_q != '0);
  assign frameError = frame_error_q;
  assign errorCode  = error_code_q;
  assign overflow   = overflow_q;
  assign fifoCount  = count_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: directed frames plus randomized batches scored
// against a frame-level model (parity by popcount, FIFO occupancy by counting).
module tb_ps2_frame_receiver;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 100;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned H     = 8;

  logic       clk = 1'b0;
  logic       sysReset;
  logic       ps2Clk;
  logic       ps2Data;
  logic       codeReady;
  logic [7:0] codeData;
  logic       codeValid;
  logic       frameError;
  logic [1:0] errorCode;
  logic       overflow;
  logic [2:0] fifoCount;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] popped[$];
  logic [1:0] err_log[$];
  int         ovf_cnt;

  logic [7:0] exp_q[$];
  logic [1:0] exp_err[$];
  int         exp_ovf;
  int         occ;

  ps2_frame_receiver #(
    .DATA_BITS(DW),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES(SYNC),
    .PARITY_ODD(1)
  ) dut (
    .clk(clk),
    .sysReset(sysReset),
    .ps2Clk(ps2Clk),
    .ps2Data(ps2Data),
    .codeData(codeData),
    .codeValid(codeValid),
    .codeReady(codeReady),
    .frameError(frameError),
    .errorCode(errorCode),
    .overflow(overflow),
    .fifoCount(fifoCount)
  );

  always #5 clk = ~clk;

  // Event logger: handshakes, error pulses, overflow pulses
  always @(negedge clk) begin
    if (!sysReset) begin
      if (codeValid && codeReady) popped.push_back(codeData);
      if (frameError) err_log.push_back(errorCode);
      if (overflow) ovf_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic clear_logs();
    popped.delete();
    err_log.delete();
    ovf_cnt = 0;
    exp_q.delete();
    exp_err.delete();
    exp_ovf = 0;
    occ = 0;
  endtask

  // Frame-level expectation: stop bit first, then odd parity over data+parity bit
  task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
    if (!s) exp_err.push_back(2'b10);
    else if ((($countones(d) + int'(p)) % 2) != 1) exp_err.push_back(2'b01);
    else if (occ < int'(DEPTH)) begin
      exp_q.push_back(d);
      occ++;
    end else exp_ovf++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2Data = f[i];
      tick(H / 2);
      ps2Clk = 1'b0;
      tick(H);
      ps2Clk = 1'b1;
      tick(H / 2);
    end
    ps2Data = 1'b1;
    tick(H);
  endtask

  task automatic drain();
    codeReady = 1'b1;
    tick(DEPTH + 3);
    codeReady = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    sysReset  = 1'b1;
    ps2Clk    = 1'b1;
    ps2Data   = 1'b1;
    codeReady = 1'b0;
    clear_logs();
    tick(3);
    n_checks++; if (codeValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", codeValid); end
    n_checks++; if (codeData !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", codeData); end
    n_checks++; if (frameError !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frameError); end
    n_checks++; if (errorCode !== 2'b00) begin n_fail++; $display("FAIL reset_ecode got %b want 00", errorCode); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_checks++; if (fifoCount !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifoCount); end
    sysReset = 1'b0;
    tick(5);
    n_checks++; if (codeValid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid got %b want 0", codeValid); end
  endtask

  task automatic test_good_frame();
    int lat;
    clear_logs();
    send_frame(8'h1C, 1'b0, 1'b1, 10);
    // stop bit: watch latency from the falling edge to codeValid
    ps2Data = 1'b1;
    tick(H / 2);
    ps2Clk = 1'b0;
    lat = 0;
    while (!codeValid && lat < 20) begin tick(1); lat++; end
    n_checks++; if (lat < int'(SYNC) || lat > int'(SYNC) + 3) begin n_fail++; $display("FAIL good_latency got %0d want %0d..%0d", lat, SYNC, SYNC + 3); end
    tick(H);
    ps2Clk = 1'b1;
    tick(H);
    n_checks++; if (codeValid !== 1'b1) begin n_fail++; $display("FAIL good_valid got %b want 1", codeValid); end
    n_checks++; if (codeData !== 8'h1C) begin n_fail++; $display("FAIL good_data got %h want 1c", codeData); end
    n_checks++; if (fifoCount !== 3'd1) begin n_fail++; $display("FAIL good_count got %0d want 1", fifoCount); end
    n_checks++; if (err_log.size() != 0) begin n_fail++; $display("FAIL good_no_err got %0d errors want 0", err_log.size()); end
    tick(10);
    n_checks++; if (codeData !== 8'h1C) begin n_fail++; $display("FAIL good_data_hold got %h want 1c", codeData); end
    drain();
    n_checks++; if (popped.size() != 1) begin n_fail++; $display("FAIL good_pop_count got %0d want 1", popped.size()); end
    n_checks++; if (fifoCount !== 3'd0 || codeValid !== 1'b0) begin n_fail++; $display("FAIL good_empty got count %0d valid %b want 0 0", fifoCount, codeValid); end
  endtask

  task automatic test_parity_error();
    clear_logs();
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    tick(4);
    n_checks++; if (err_log.size() != 1) begin n_fail++; $display("FAIL parity_err_count got %0d want 1", err_log.size()); end
    else begin
      n_checks++; if (err_log[0] !== 2'b01) begin n_fail++; $display("FAIL parity_code got %b want 01", err_log[0]); end
    end
    n_checks++; if (errorCode !== 2'b01) begin n_fail++; $display("FAIL parity_code_held got %b want 01", errorCode); end
    n_checks++; if (codeValid !== 1'b0) begin n_fail++; $display("FAIL parity_valid got %b want 0", codeValid); end
  endtask

  task automatic test_stop_error();
    clear_logs();
    send_frame(8'hF0, odd_par(8'hF0), 1'b0, 11);
    tick(4);
    n_checks++; if (err_log.size() != 1 || errorCode !== 2'b10) begin n_fail++; $display("FAIL stop_err got %0d errors code %b want 1 10", err_log.size(), errorCode); end
    n_checks++; if (codeValid !== 1'b0) begin n_fail++; $display("FAIL stop_valid got %b want 0", codeValid); end
    send_frame(8'h12, odd_par(8'h12), 1'b1, 11);
    tick(4);
    n_checks++; if (codeValid !== 1'b1 || codeData !== 8'h12) begin n_fail++; $display("FAIL stop_next got valid %b data %h want 1 12", codeValid, codeData); end
    n_checks++; if (err_log.size() != 1) begin n_fail++; $display("FAIL stop_next_err got %0d errors want 1", err_log.size()); end
    drain();
  endtask

  task automatic test_timeout();
    int k;
    clear_logs();
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    // cycles elapsed since the last falling edge: H low + H/2 high + H idle
    k = int'(H + H / 2 + H);
    while (!frameError && k < int'(TMO) + 40) begin tick(1); k++; end
    n_checks++; if (k < int'(TMO) || k > int'(TMO) + int'(SYNC) + 3) begin n_fail++; $display("FAIL timeout_time got %0d want %0d..%0d", k, TMO, TMO + SYNC + 3); end
    n_checks++; if (errorCode !== 2'b11) begin n_fail++; $display("FAIL timeout_code got %b want 11", errorCode); end
    tick(3);
    n_checks++; if (err_log.size() != 1) begin n_fail++; $display("FAIL timeout_err_count got %0d want 1", err_log.size()); end
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    tick(4);
    n_checks++; if (codeValid !== 1'b1 || codeData !== 8'h1C) begin n_fail++; $display("FAIL timeout_next got valid %b data %h want 1 1c", codeValid, codeData); end
    n_checks++; if (err_log.size() != 1) begin n_fail++; $display("FAIL timeout_next_err got %0d errors want 1", err_log.size()); end
    drain();
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    clear_logs();
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, odd_par(d), 1'b1, 11);
      model_frame(d, odd_par(d), 1'b1);
    end
    tick(4);
    n_checks++; if (fifoCount !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", fifoCount); end
    n_checks++; if (ovf_cnt != exp_ovf) begin n_fail++; $display("FAIL ovf_pulses got %0d want %0d", ovf_cnt, exp_ovf); end
    n_checks++; if (codeData !== 8'h01) begin n_fail++; $display("FAIL ovf_head got %h want 01", codeData); end
    drain();
    n_checks++; if (popped.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_pop_count got %0d want %0d", popped.size(), exp_q.size()); end
    for (int i = 0; i < popped.size() && i < exp_q.size(); i++) begin
      n_checks++; if (popped[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_pop_%0d got %h want %h", i, popped[i], exp_q[i]); end
    end
    n_checks++; if (fifoCount !== 3'd0) begin n_fail++; $display("FAIL ovf_drained got %0d want 0", fifoCount); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'hA5, odd_par(8'hA5), 1'b1, 6);
    sysReset = 1'b1;
    tick(3);
    sysReset = 1'b0;
    tick(5);
    clear_logs();
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    tick(4);
    n_checks++; if (err_log.size() != 0) begin n_fail++; $display("FAIL midreset_err got %0d errors want 0", err_log.size()); end
    n_checks++; if (codeValid !== 1'b1 || codeData !== 8'h1C) begin n_fail++; $display("FAIL midreset_data got valid %b data %h want 1 1c", codeValid, codeData); end
    n_checks++; if (fifoCount !== 3'd1) begin n_fail++; $display("FAIL midreset_count got %0d want 1", fifoCount); end
    drain();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       p;
    logic       s;
    int         nf;
    for (int b = 0; b < 8; b++) begin
      clear_logs();
      nf = int'($urandom_range(1, 6));
      for (int i = 0; i < nf; i++) begin
        d = 8'($urandom);
        p = odd_par(d) ^ (($urandom % 5) == 0);
        s = ($urandom % 8) != 0;
        send_frame(d, p, s, 11);
        model_frame(d, p, s);
      end
      tick(4);
      n_checks++; if (fifoCount !== 3'(occ)) begin n_fail++; $display("FAIL rnd%0d_count got %0d want %0d", b, fifoCount, occ); end
      n_checks++; if (ovf_cnt != exp_ovf) begin n_fail++; $display("FAIL rnd%0d_ovf got %0d want %0d", b, ovf_cnt, exp_ovf); end
      n_checks++; if (err_log.size() != exp_err.size()) begin n_fail++; $display("FAIL rnd%0d_err_count got %0d want %0d", b, err_log.size(), exp_err.size()); end
      for (int i = 0; i < err_log.size() && i < exp_err.size(); i++) begin
        n_checks++; if (err_log[i] !== exp_err[i]) begin n_fail++; $display("FAIL rnd%0d_err_%0d got %b want %b", b, i, err_log[i], exp_err[i]); end
      end
      drain();
      n_checks++; if (popped.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_pop_count got %0d want %0d", b, popped.size(), exp_q.size()); end
      for (int i = 0; i < popped.size() && i < exp_q.size(); i++) begin
        n_checks++; if (popped[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_pop_%0d got %h want %h", b, i, popped[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_stop_error();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
